// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime parity/stop configuration, error/break detection and an RX FIFO.
// Optional build macro UART_RX_MAJORITY_EN: 3-sample majority vote around each bit sample point.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_en_i,
    input  logic                          rx_i,
    input  logic [15:0]                   clks_per_bit_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          stop2_i,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [DATA_W-1:0]             rx_data_o,
    output logic                          rx_perr_o,
    output logic                          rx_ferr_o,
    output logic                          rx_break_o,
    output logic                          overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          busy_o
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int ENT_W = DATA_W + 3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2, ST_BRK_WAIT
    } state_e;

    function automatic logic parity_err_f(input logic [DATA_W-1:0] d, input logic p,
                                          input logic odd);
        return (((^d) ^ p) != odd);
    endfunction

`ifdef UART_RX_MAJORITY_EN
    function automatic logic maj3_f(input logic a, input logic b, input logic c);
        return ((a & b) | (a & c) | (b & c));
    endfunction
`endif

    state_e              state_r, state_n;
    logic                rx_meta_r, rxs_r;
    logic [15:0]         cpb_r, cnt_r, cnt_n;
    logic                par_en_r, par_odd_r, stop2_r;
    logic [3:0]          bit_idx_r, bit_idx_n;
    logic [DATA_W-1:0]   data_r, data_n;
    logic                pbit_r, pbit_n;
    logic                start_s, sample_s, bit_end_s;
    logic [15:0]         half_s;
    logic                push_s, push_ferr_s, push_brk_s, push_perr_s;
    logic [ENT_W-1:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]    level_r;
    logic                overrun_r;
    logic                pop_s, full_s, wr_en_s;
    logic [ENT_W-1:0]    head_s;

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rxs_r     <= rx_meta_r;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rxs_d_r;
    // One-cycle history of the synchronised line; rx_meta_r serves as the +1 sample
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxs_d_r <= 1'b1;
        end else begin
            rxs_d_r <= rxs_r;
        end
    end
    assign sample_s = maj3_f(rx_meta_r, rxs_r, rxs_d_r);
`else
    assign sample_s = rxs_r;
`endif

    assign half_s    = (cpb_r - 16'd1) >> 1;
    assign bit_end_s = (cnt_r == (cpb_r - 16'd1));

    // Frame configuration captured at start detection so mid-frame changes are ignored
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpb_r     <= 16'd0;
            par_en_r  <= 1'b0;
            par_odd_r <= 1'b0;
            stop2_r   <= 1'b0;
        end else if (start_s) begin
            cpb_r     <= clks_per_bit_i;
            par_en_r  <= parity_en_i;
            par_odd_r <= parity_odd_i;
            stop2_r   <= stop2_i;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            bit_idx_r <= 4'd0;
            data_r    <= {DATA_W{1'b0}};
            pbit_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            bit_idx_r <= bit_idx_n;
            data_r    <= data_n;
            pbit_r    <= pbit_n;
        end
    end

    // Next-state logic; the frame is pushed at the final stop-bit sample
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        bit_idx_n   = bit_idx_r;
        data_n      = data_r;
        pbit_n      = pbit_r;
        start_s     = 1'b0;
        push_s      = 1'b0;
        push_ferr_s = 1'b0;
        push_brk_s  = 1'b0;
        push_perr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rxs_r && rx_en_i && (clks_per_bit_i >= 16'd4)) begin
                    state_n = ST_START;
                    cnt_n   = 16'd0;
                    start_s = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == half_s) begin
                    if (sample_s) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n   = ST_DATA;
                        cnt_n     = 16'd0;
                        bit_idx_n = 4'd0;
                    end
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_n  = 16'd0;
                    data_n = {sample_s, data_r[DATA_W-1:1]};
                    if (bit_idx_r == 4'(DATA_W - 1)) begin
                        state_n = par_en_r ? ST_PARITY : ST_STOP1;
                    end else begin
                        bit_idx_n = bit_idx_r + 4'd1;
                    end
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    cnt_n   = 16'd0;
                    pbit_n  = sample_s;
                    state_n = ST_STOP1;
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            ST_STOP1: begin
                if (bit_end_s) begin
                    cnt_n = 16'd0;
                    if (sample_s && stop2_r) begin
                        state_n = ST_STOP2;
                    end else begin
                        push_s      = 1'b1;
                        push_ferr_s = !sample_s;
                        push_perr_s = par_en_r & parity_err_f(data_r, pbit_r, par_odd_r);
                        // Break: line low through data, parity and stop
                        push_brk_s  = !sample_s && (data_r == {DATA_W{1'b0}}) &&
                                      (!par_en_r || !pbit_r);
                        state_n     = push_brk_s ? ST_BRK_WAIT : ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            ST_STOP2: begin
                if (bit_end_s) begin
                    cnt_n       = 16'd0;
                    push_s      = 1'b1;
                    push_ferr_s = !sample_s;
                    push_perr_s = par_en_r & parity_err_f(data_r, pbit_r, par_odd_r);
                    state_n     = ST_IDLE;
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            ST_BRK_WAIT: begin
                if (rxs_r) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_BRK_WAIT;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign pop_s   = rx_ready_i && (level_r != {LVL_W{1'b0}});
    assign full_s  = (level_r == LVL_W'(FIFO_DEPTH));
    // A full FIFO still accepts the push when the head leaves in the same cycle
    assign wr_en_s = push_s && (!full_s || pop_s);

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {push_brk_s, push_ferr_s, push_perr_s, data_r};
        end
    end

    // FIFO pointers, occupancy and overrun pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            level_r   <= {LVL_W{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r   <= level_r + LVL_W'(wr_en_s) - LVL_W'(pop_s);
            overrun_r <= push_s && full_s && !pop_s;
        end
    end

    assign head_s       = mem_r[rd_ptr_r];
    assign rx_valid_o   = (level_r != {LVL_W{1'b0}});
    assign rx_data_o    = rx_valid_o ? head_s[DATA_W-1:0] : {DATA_W{1'b0}};
    assign rx_perr_o    = rx_valid_o & head_s[DATA_W];
    assign rx_ferr_o    = rx_valid_o & head_s[DATA_W+1];
    assign rx_break_o   = rx_valid_o & head_s[DATA_W+2];
    assign overrun_o    = overrun_r;
    assign fifo_level_o = level_r;
    assign busy_o       = (state_r != ST_IDLE);

endmodule
